// File: rtl/uart_filter_rx_multi_if.sv
// Signal bundle between the rxd pins/control and the multi-channel majority filter.
// No valid/ready pairs: every signal is level-valid on every clock; inputs are sampled each cycle.
interface uart_filter_rx_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       rxd_in;
  logic                      bypass;
  logic                      cnt_clr;
  logic [CHANNELS-1:0]       rxd_filtered;
  logic [CHANNELS-1:0]       rise_pulse;
  logic [CHANNELS-1:0]       fall_pulse;
  logic [CHANNELS*CNT_W-1:0] edge_cnt;

  modport master (
    output rxd_in, bypass, cnt_clr,
    input  rxd_filtered, rise_pulse, fall_pulse, edge_cnt
  );

  modport slave (
    input  rxd_in, bypass, cnt_clr,
    output rxd_filtered, rise_pulse, fall_pulse, edge_cnt
  );
endinterface

// File: rtl/uart_filter_rx_multi.sv
// Multi-channel rxd filter: synchroniser, sliding-window majority vote with hysteresis,
// filtered-edge pulses and a saturating raw-edge counter per channel.
module uart_filter_rx_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 7,
  parameter int HYST        = 0,
  parameter bit IDLE_LEVEL  = 1'b1,
  parameter int CNT_W       = 8
) (
  input logic                   clk,
  input logic                   rst,
  uart_filter_rx_multi_if.slave bus
);

  localparam int SUM_W = $clog2(WINDOW + 1);
  localparam logic [SUM_W-1:0] TH_HI   = SUM_W'((WINDOW + 1) / 2 + HYST);
  localparam logic [SUM_W-1:0] TH_LO   = SUM_W'((WINDOW - 1) / 2 - HYST);
  localparam logic [SUM_W-1:0] SUM_RST = IDLE_LEVEL ? SUM_W'(WINDOW) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [WINDOW-2:0]      win_q, win_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic                   filt_q, filt_d;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   samp;
    logic                   samp_edge;

    // win_q[0] is the previous synchronised sample, so it doubles as the edge reference.
    assign samp      = sync_q[SYNC_STAGES-1];
    assign samp_edge = samp ^ win_q[0];

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.rxd_in[ch]};
      win_d  = {win_q[WINDOW-3:0], samp};

      sum_d = SUM_W'(samp);
      for (int k = 0; k < WINDOW - 1; k++) begin
        sum_d = sum_d + SUM_W'(win_q[k]);
      end

      // Between the two thresholds the output holds its last decision.
      filt_d = filt_q;
      if (bus.bypass) begin
        filt_d = samp;
      end else if (sum_q >= TH_HI) begin
        filt_d = 1'b1;
      end else if (sum_q <= TH_LO) begin
        filt_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (bus.cnt_clr) begin
        cnt_d = '0;
      end else if (samp_edge && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        win_q  <= {(WINDOW-1){IDLE_LEVEL}};
        sum_q  <= SUM_RST;
        filt_q <= IDLE_LEVEL;
        prev_q <= IDLE_LEVEL;
        cnt_q  <= '0;
      end else begin
        sync_q <= sync_d;
        win_q  <= win_d;
        sum_q  <= sum_d;
        filt_q <= filt_d;
        prev_q <= filt_q;
        cnt_q  <= cnt_d;
      end
    end

    assign bus.rxd_filtered[ch]               = filt_q;
    assign bus.rise_pulse[ch]                 = filt_q & ~prev_q;
    assign bus.fall_pulse[ch]                 = ~filt_q & prev_q;
    assign bus.edge_cnt[ch*CNT_W +: CNT_W]    = cnt_q;
  end

endmodule

// File: tb/tb_uart_filter_rx_multi.sv
// Bench for uart_filter_rx_multi: default, HYST=1 and CNT_W=3 instances, pulse scoreboard.
module tb_uart_filter_rx_multi;
  localparam int CH = 4;
  localparam int EW = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CH-1:0] rxd_a;
  logic [CH-1:0] rxd_c;
  logic          byp;
  logic          clr;
  logic          hy_seen;
  bit            mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs;
  logic [EW-1:0] exp_item;

  uart_filter_rx_multi_if #(.CHANNELS(CH), .CNT_W(8)) if_main ();
  uart_filter_rx_multi_if #(.CHANNELS(CH), .CNT_W(8)) if_hyst ();
  uart_filter_rx_multi_if #(.CHANNELS(CH), .CNT_W(3)) if_cnt ();

  assign if_main.rxd_in  = rxd_a;
  assign if_main.bypass  = byp;
  assign if_main.cnt_clr = clr;
  assign if_hyst.rxd_in  = rxd_a;
  assign if_hyst.bypass  = byp;
  assign if_hyst.cnt_clr = clr;
  assign if_cnt.rxd_in   = rxd_c;
  assign if_cnt.bypass   = byp;
  assign if_cnt.cnt_clr  = clr;

  uart_filter_rx_multi #(.CHANNELS(CH), .SYNC_STAGES(2), .WINDOW(7), .HYST(0),
                         .IDLE_LEVEL(1'b1), .CNT_W(8))
    u_main (.clk(clk), .rst(rst), .bus(if_main));

  uart_filter_rx_multi #(.CHANNELS(CH), .SYNC_STAGES(2), .WINDOW(7), .HYST(1),
                         .IDLE_LEVEL(1'b1), .CNT_W(8))
    u_hyst (.clk(clk), .rst(rst), .bus(if_hyst));

  uart_filter_rx_multi #(.CHANNELS(CH), .SYNC_STAGES(2), .WINDOW(7), .HYST(0),
                         .IDLE_LEVEL(1'b1), .CNT_W(3))
    u_cnt (.clk(clk), .rst(rst), .bus(if_cnt));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse: cycle index of the posedge after which it is visible, channel, 1=rise.
  task automatic push_evt(input int at, input int ch, input bit rise);
    exp_q.push_back({16'(at), 4'(ch), rise});
  endtask

  task automatic hold_ch2(input logic v, input int n);
    rxd_a[2] = v;
    repeat (n) begin
      @(negedge clk);
      hy_seen = hy_seen | if_hyst.rxd_filtered[2];
    end
  endtask

  // ---------------- scoreboard: pulses of the default instance ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < CH; c++) begin
        if (if_main.rise_pulse[c] || if_main.fall_pulse[c]) begin
          obs = {16'(cyc), 4'(c), if_main.rise_pulse[c]};
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", obs, '0);
          end else begin
            exp_item = exp_q.pop_front();
            check("pulse", obs, exp_item);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    rxd_a = '1;
    rxd_c = '1;
    byp   = 1'b0;
    clr   = 1'b0;
    hy_seen = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    mon_en = 1'b1;

    // reset / idle
    check("rst_filt", if_main.rxd_filtered, 4'hF);
    check("rst_rise", if_main.rise_pulse, 4'h0);
    check("rst_fall", if_main.fall_pulse, 4'h0);
    check("rst_cnt", if_main.edge_cnt, 0);
    check("rst_cnt_small", if_cnt.edge_cnt, 0);

    // clean step on ch0
    rxd_a[0] = 1'b0;
    push_evt(cyc + 7, 0, 1'b0);
    wait_cyc(20);
    check("step_cnt0", if_main.edge_cnt[7:0], 1);
    check("step_filt", if_main.rxd_filtered, 4'hE);
    check("step_cnt_rest", if_main.edge_cnt[31:8], 0);
    rxd_a[0] = 1'b1;
    push_evt(cyc + 7, 0, 1'b1);
    wait_cyc(20);
    check("step_back_cnt0", if_main.edge_cnt[7:0], 2);

    // glitches on ch1 of 1..3 samples are rejected
    for (int len = 1; len <= 3; len++) begin
      rxd_a[1] = 1'b0;
      wait_cyc(len);
      rxd_a[1] = 1'b1;
      wait_cyc(10);
    end
    check("glitch_filt", if_main.rxd_filtered, 4'hF);
    check("glitch_cnt1", if_main.edge_cnt[15:8], 6);
    rxd_a[1] = 1'b0;
    push_evt(cyc + 7, 1, 1'b0);
    push_evt(cyc + 11, 1, 1'b1);
    wait_cyc(4);
    rxd_a[1] = 1'b1;
    wait_cyc(16);
    check("pulse4_cnt1", if_main.edge_cnt[15:8], 8);

    // 4-high/3-low on ch2 after a long low: HYST=1 never rises, HYST=0 rises once
    rxd_a[2] = 1'b0;
    push_evt(cyc + 7, 2, 1'b0);
    wait_cyc(20);
    check("hyst_low", if_hyst.rxd_filtered[2], 1'b0);
    hy_seen = 1'b0;
    push_evt(cyc + 7, 2, 1'b1);
    for (int p = 0; p < 5; p++) begin
      hold_ch2(1'b1, 4);
      hold_ch2(1'b0, 3);
    end
    check("hyst_no_rise", hy_seen, 1'b0);
    check("nohyst_high", if_main.rxd_filtered[2], 1'b1);
    rxd_a[2] = 1'b1;
    wait_cyc(20);
    check("hyst_rise_late", if_hyst.rxd_filtered[2], 1'b1);

    // bypass: single-cycle low on ch3 passes through after 3 edges
    byp = 1'b1;
    wait_cyc(3);
    rxd_a[3] = 1'b0;
    push_evt(cyc + 3, 3, 1'b0);
    push_evt(cyc + 4, 3, 1'b1);
    wait_cyc(1);
    rxd_a[3] = 1'b1;
    wait_cyc(10);
    byp = 1'b0;
    wait_cyc(10);
    check("byp_filt", if_main.rxd_filtered, 4'hF);
    check("byp_cnt3", if_main.edge_cnt[31:24], 2);

    // saturating 3-bit counter
    for (int i = 0; i < 20; i++) begin
      rxd_c[0] = ~rxd_c[0];
      wait_cyc(2);
    end
    wait_cyc(4);
    check("sat_cnt0", if_cnt.edge_cnt[2:0], 7);
    check("sat_cnt_rest", if_cnt.edge_cnt[11:3], 0);

    rxd_c[0] = ~rxd_c[0];
    wait_cyc(2);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    check("clr_coincident", if_cnt.edge_cnt[2:0], 0);
    check("clr_main", if_main.edge_cnt, 0);
    wait_cyc(4);
    check("clr_edge_lost", if_cnt.edge_cnt[2:0], 0);
    rxd_c[0] = ~rxd_c[0];
    wait_cyc(4);
    check("after_clr", if_cnt.edge_cnt[2:0], 1);

    // reset in the middle of toggling
    for (int i = 0; i < 6; i++) begin
      rxd_c[0] = ~rxd_c[0];
      wait_cyc(2);
    end
    rst = 1'b1;
    rxd_c[0] = ~rxd_c[0];
    wait_cyc(1);
    check("rst_mid_cnt", if_cnt.edge_cnt, 0);
    check("rst_mid_filt", if_cnt.rxd_filtered, 4'hF);
    check("rst_mid_pulse", {if_cnt.rise_pulse, if_cnt.fall_pulse}, 0);
    check("rst_mid_main", if_main.edge_cnt, 0);
    rst = 1'b0;
    rxd_c = '1;
    wait_cyc(10);

    mon_en = 1'b0;
    check("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
